// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification for the multicycle ALU.
package alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_ADD   = 5'h00;
  localparam logic [OPW-1:0] OP_SUB   = 5'h01;
  localparam logic [OPW-1:0] OP_SLL   = 5'h02;
  localparam logic [OPW-1:0] OP_SRL   = 5'h03;
  localparam logic [OPW-1:0] OP_SLLV  = 5'h04;
  localparam logic [OPW-1:0] OP_SRLV  = 5'h05;
  localparam logic [OPW-1:0] OP_SRAV  = 5'h06;
  localparam logic [OPW-1:0] OP_AND   = 5'h07;
  localparam logic [OPW-1:0] OP_NAND  = 5'h08;
  localparam logic [OPW-1:0] OP_OR    = 5'h09;
  localparam logic [OPW-1:0] OP_NOR   = 5'h0A;
  localparam logic [OPW-1:0] OP_XOR   = 5'h0B;
  localparam logic [OPW-1:0] OP_XNOR  = 5'h0C;
  localparam logic [OPW-1:0] OP_SLTU  = 5'h0D;
  localparam logic [OPW-1:0] OP_SLT   = 5'h0F;
  localparam logic [OPW-1:0] OP_MULLO = 5'h10;
  localparam logic [OPW-1:0] OP_MULHI = 5'h11;
  localparam logic [OPW-1:0] OP_DIVU  = 5'h12;
  localparam logic [OPW-1:0] OP_REMU  = 5'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [OPW-1:0] op);
    return (op == OP_MULLO) || (op == OP_MULHI) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iterative_muldiv_core.sv
// Radix-2 shift-add multiplier and restoring divider sharing one 2*DWL accumulator.
// The accumulator starts as {0, op_a}: multiplier in the low half for MUL, dividend for DIV.
module iterative_muldiv_core #(
  parameter int DWL = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_div,
  input  logic           sel_hi,
  input  logic [DWL-1:0] op_a,
  input  logic [DWL-1:0] op_b,
  output logic           last,
  output logic [DWL-1:0] result
);

  logic [2*DWL-1:0] acc_q, acc_d;
  logic [DWL-1:0]   opb_q, opb_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic             hi_q, hi_d;

  logic [DWL:0]     mul_sum;
  logic [2*DWL-1:0] mul_next;
  logic [2*DWL:0]   div_shift;
  logic [DWL:0]     div_rext;
  logic [DWL:0]     div_diff;
  logic             div_ge;
  logic [2*DWL-1:0] div_next;
  logic [2*DWL-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DWL-1:DWL]} + (acc_q[0] ? {1'b0, opb_q} : {(DWL+1){1'b0}});
    mul_next  = {mul_sum, acc_q[DWL-1:1]};
    div_shift = {acc_q, 1'b0};
    div_rext  = div_shift[2*DWL:DWL];
    div_diff  = div_rext - {1'b0, opb_q};
    // Explicit compare so a zero divisor naturally yields all-ones quotient and remainder = dividend
    div_ge    = (div_rext >= {1'b0, opb_q});
    div_next  = {(div_ge ? div_diff[DWL-1:0] : div_rext[DWL-1:0]), div_shift[DWL-1:1], div_ge};
    step      = div_q ? div_next : mul_next;
    result    = hi_q ? step[2*DWL-1:DWL] : step[DWL-1:0];
    last      = busy_q && (cnt_q == SHW'(DWL-1));
  end

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    hi_d   = hi_q;
    if (start) begin
      acc_d  = {{DWL{1'b0}}, op_a};
      opb_d  = op_b;
      cnt_d  = '0;
      busy_d = 1'b1;
      div_d  = is_div;
      hi_d   = sel_hi;
    end else if (busy_q) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
    end
  end

endmodule

// File: rtl/multicycle_alu_unit.sv
// Registered-output ALU with valid/ready handshakes; single-cycle ops plus iterative mul/div.
//  state  | meaning
//  S_IDLE | ready for a new operation
//  S_BUSY | mul/div core iterating (DWL cycles)
//  S_DONE | result valid, waiting for out_ready
module multicycle_alu_unit
  import alu_pkg::*;
#(
  parameter int DWL  = 32,
  parameter int SHW  = 5,
  parameter int SELW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SELW-1:0] alu_sel,
  input  logic [DWL-1:0]  alu_in1,
  input  logic [DWL-1:0]  alu_in2,
  input  logic [SHW-1:0]  shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DWL-1:0]  alu_out,
  output logic            zero,
  output logic            div_by_zero,
  output logic            illegal_op
);

  state_t         state_q, state_d;
  logic [DWL-1:0] alu_out_q, alu_out_d;
  logic           dbz_q, dbz_d;
  logic           ill_q, ill_d;

  logic [DWL-1:0] sc_result;
  logic           sc_illegal;
  logic [SHW-1:0] shv;
  logic           slt_s, slt_u;
  logic           is_divop;
  logic           core_start;
  logic           core_last;
  logic [DWL-1:0] core_result;

  assign shv      = alu_in1[SHW-1:0];
  assign slt_s    = $signed(alu_in1) < $signed(alu_in2);
  assign slt_u    = alu_in1 < alu_in2;
  assign is_divop = (alu_sel == OP_DIVU) || (alu_sel == OP_REMU);

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (alu_sel)
      OP_ADD:   sc_result = alu_in1 + alu_in2;
      OP_SUB:   sc_result = alu_in1 - alu_in2;
      OP_SLL:   sc_result = alu_in2 << shamt;
      OP_SRL:   sc_result = alu_in2 >> shamt;
      OP_SLLV:  sc_result = alu_in2 << shv;
      OP_SRLV:  sc_result = alu_in2 >> shv;
      OP_SRAV:  sc_result = $unsigned($signed(alu_in2) >>> shv);
      OP_AND:   sc_result = alu_in1 & alu_in2;
      OP_NAND:  sc_result = ~(alu_in1 & alu_in2);
      OP_OR:    sc_result = alu_in1 | alu_in2;
      OP_NOR:   sc_result = ~(alu_in1 | alu_in2);
      OP_XOR:   sc_result = alu_in1 ^ alu_in2;
      OP_XNOR:  sc_result = ~(alu_in1 ^ alu_in2);
      OP_SLTU:  sc_result = {{(DWL-1){1'b0}}, slt_u};
      OP_SLT:   sc_result = {{(DWL-1){1'b0}}, slt_s};
      OP_MULLO, OP_MULHI, OP_DIVU, OP_REMU: sc_result = '0;
      default:  sc_illegal = 1'b1;
    endcase
  end

  iterative_muldiv_core #(
    .DWL (DWL),
    .SHW (SHW)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .is_div (is_divop),
    .sel_hi ((alu_sel == OP_MULHI) || (alu_sel == OP_REMU)),
    .op_a   (alu_in1),
    .op_b   (alu_in2),
    .last   (core_last),
    .result (core_result)
  );

  always_comb begin
    state_d    = state_q;
    alu_out_d  = alu_out_q;
    dbz_d      = dbz_q;
    ill_d      = ill_q;
    core_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dbz_d = 1'b0;
          ill_d = 1'b0;
          if (is_multicycle(alu_sel)) begin
            core_start = 1'b1;
            dbz_d      = is_divop && (alu_in2 == '0);
            state_d    = S_BUSY;
          end else begin
            alu_out_d = sc_result;
            ill_d     = sc_illegal;
            state_d   = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (core_last) begin
          alu_out_d = core_result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      alu_out_q <= '0;
      dbz_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      dbz_q     <= dbz_d;
      ill_q     <= ill_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign alu_out     = alu_out_q;
  assign zero        = (alu_out_q == '0);
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_multicycle_alu_unit.sv
// Randomized and directed checks of multicycle_alu_unit against an arithmetic reference model.
module tb_multicycle_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_sel = '0;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_out;
  logic        zero;
  logic        div_by_zero;
  logic        illegal_op;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_alu_unit #(.DWL(32), .SHW(5), .SELW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_sel     (alu_sel),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // returns {illegal, div_by_zero, result}
  function automatic logic [33:0] model(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh);
    logic [63:0] p;
    logic [31:0] r;
    logic dz, il;
    r  = '0;
    dz = 1'b0;
    il = 1'b0;
    p  = {32'b0, a} * {32'b0, b};
    case (s)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = b << sh;
      5'h03: r = b >> sh;
      5'h04: r = b << a[4:0];
      5'h05: r = b >> a[4:0];
      5'h06: r = $unsigned($signed(b) >>> a[4:0]);
      5'h07: r = a & b;
      5'h08: r = ~(a & b);
      5'h09: r = a | b;
      5'h0A: r = ~(a | b);
      5'h0B: r = a ^ b;
      5'h0C: r = ~(a ^ b);
      5'h0D: r = (a < b) ? 32'd1 : 32'd0;
      5'h0F: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h10: r = p[31:0];
      5'h11: r = p[63:32];
      5'h12: begin if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end else r = a / b; end
      5'h13: begin if (b == 0) begin r = a; dz = 1'b1; end else r = a % b; end
      default: il = 1'b1;
    endcase
    return {il, dz, r};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble_inputs();
    alu_sel = 5'($urandom);
    alu_in1 = $urandom;
    alu_in2 = $urandom;
    shamt   = 5'($urandom);
  endtask

  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit bp);
    logic [33:0] exp;
    int lat, w;
    int exp_lat;
    exp     = model(sel, a, b, sh);
    exp_lat = (sel >= 5'h10 && sel <= 5'h13) ? 33 : 1;
    @(negedge clk);
    alu_sel = sel; alu_in1 = a; alu_in2 = b; shamt = sh;
    in_valid = 1'b1; out_ready = !bp;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk($sformatf("latency op%0h", sel), 64'(lat), 64'(exp_lat));
    chk($sformatf("alu_out op%0h", sel), 64'(alu_out), 64'(exp[31:0]));
    chk($sformatf("zero op%0h", sel), 64'(zero), 64'(exp[31:0] == 0));
    chk($sformatf("dbz op%0h", sel), 64'(div_by_zero), 64'(exp[32]));
    chk($sformatf("illegal op%0h", sel), 64'(illegal_op), 64'(exp[33]));
    if (bp) begin
      repeat (10) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        scramble_inputs();
        @(posedge clk); #1;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_alu_out", 64'(alu_out), 64'(exp[31:0]));
        chk("bp_flags", {61'd0, zero, div_by_zero, illegal_op},
            {61'd0, exp[31:0] == 0, exp[32], exp[33]});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("consume_out_valid", 64'(out_valid), 64'd0);
    chk("consume_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic reset_mid_divu();
    @(negedge clk);
    alu_sel = 5'h12; alu_in1 = 32'd100; alu_in2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_out", 64'(alu_out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {62'd0, in_ready, out_valid}, 64'd2);
    end
  endtask

  initial begin
    logic [4:0] s;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_alu_out", 64'(alu_out), 64'd0);
    chk("reset_flags", {61'd0, zero, div_by_zero, illegal_op}, 64'd4);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(5'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op(5'h0F, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op(5'h0D, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op(5'h06, 32'h24, 32'h8000_0000, 5'd0, 1'b0);
    run_op(5'h02, 32'd1, 32'd1, 5'd31, 1'b0);
    run_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op(5'h12, 32'd100, 32'd7, 5'd0, 1'b0);
    run_op(5'h13, 32'd100, 32'd7, 5'd0, 1'b0);
    run_op(5'h12, 32'd5, 32'd0, 5'd0, 1'b0);
    run_op(5'h13, 32'd5, 32'd0, 5'd0, 1'b0);
    run_op(5'h0E, 32'h1234, 32'h5678, 5'd3, 1'b0);
    run_op(5'h13, 32'd5, 32'd0, 5'd0, 1'b1);
    run_op(5'h01, 32'd3, 32'd9, 5'd0, 1'b1);

    reset_mid_divu();

    for (int i = 0; i < 60; i++) begin
      s = 5'($urandom_range(0, 31));
      run_op(s, rnd_val(), rnd_val(), 5'($urandom), (i % 10) == 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
